prescaled_counter: RTL
======================

PRESCALED_COUNTER -- requirements
Module: prescaled_counter

Interface
REQ-001 The block SHALL have parameter COUNTER_WIDTH, default 16, which sets the width of val, max and cmp.
REQ-002 The block SHALL have parameter PRESCALE_WIDTH, default 8, which sets the width of prescale.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port en, input, 1 bit: count-enable strobe, sampled each clk.
REQ-006 Ports start and stop, input, 1 bit each: run-control pulses.
REQ-007 Port mode, input, 2 bits: mode_t selecting PERIODIC, ONESHOT or UPDOWN.
REQ-008 Ports max and cmp, input, COUNTER_WIDTH each: terminal value and compare value.
REQ-009 Port prescale, input, PRESCALE_WIDTH: number of en strobes per tick, minus one.
REQ-010 Port val, output, COUNTER_WIDTH: current count (registered).
REQ-011 Port top, output, 1 bit: high while val equals the latched max (combinational from registers).
REQ-012 Ports top_pulse and cmp_pulse, output, 1 bit each: registered single-cycle events.
REQ-013 Ports dir and busy, output, 1 bit each: dir is 1 when counting down; busy is 1 in RUN.

Function
REQ-014 The FSM SHALL have three states, IDLE, RUN and DONE, with IDLE as the reset state.
REQ-015 tick SHALL be asserted when en=1 and the prescaler count equals the latched prescale; the prescaler then returns to 0, otherwise it increments on each en; prescale=0 gives one tick per en.
REQ-016 start in any state SHALL enter RUN and, on the same edge, set val=0, dir=0 and prescaler=0, and latch mode, max and prescale.
REQ-017 Latched mode, max and prescale SHALL stay fixed until the next start; input changes while running are ignored.
REQ-018 stop SHALL move RUN or DONE to IDLE with val frozen; stop takes priority over a simultaneous start.
REQ-019 PERIODIC: on tick, val>=max gives val=0; otherwise val increments.
REQ-020 ONESHOT: on tick at val>=max, the state SHALL go to DONE with val held at max; DONE ignores ticks.
REQ-021 UPDOWN: counting up, reaching max sets dir=1; counting down, reaching 0 sets dir=0; there is no dwell at either end.
REQ-022 UPDOWN with max=0 SHALL keep val=0 and dir=0, with top_pulse on every tick.
REQ-023 top_pulse SHALL be high for exactly one cycle after each edge where a tick in RUN loads val==max; with max=0, this happens on every tick.
REQ-024 cmp_pulse SHALL be high for exactly one cycle after each tick edge that loads val==cmp, including cmp==0 after a wrap; start itself produces no pulse.
REQ-025 val arithmetic SHALL be modulo 2^COUNTER_WIDTH; max = all-ones SHALL wrap cleanly to 0.
REQ-026 In IDLE and DONE, top_pulse and cmp_pulse SHALL be 0.

Reset
REQ-027 Asserting reset SHALL immediately, without a clock edge, set state=IDLE and clear val, dir, prescaler, top_pulse, cmp_pulse, busy and the latched registers.
REQ-028 Reset asserted mid-RUN SHALL abort the count; after release, the block SHALL stay idle until start.

Structure
REQ-029 Package counter_pkg SHALL hold mode_t (PERIODIC=0, ONESHOT=1, UPDOWN=2, with 3 treated as PERIODIC) and state_t.
REQ-030 The prescaler SHALL be a separate sub-module, prescaler, with ports clk, reset, en, clear, div and tick.

Verification
REQ-031 PERIODIC, max=3, prescale=0, en held high, then start: val SHALL run 0,1,2,3,0,1; top_pulse SHALL occur once per 4 cycles, each pulse one cycle wide.
REQ-032 prescale=2, PERIODIC, max=7, en high: val SHALL increment every 3rd cycle.
REQ-033 ONESHOT, max=5: val SHALL stop at 5 in DONE with busy=0 and a single top_pulse; a further start SHALL restart from 0.
REQ-034 UPDOWN, max=3: val SHALL run 0,1,2,3,2,1,0,1; dir SHALL be 1 from the cycle after val reaches 3 until the cycle after val reaches 0.
REQ-035 cmp=2, PERIODIC, max=4: cmp_pulse SHALL occur once per period; start and stop in the same cycle SHALL give IDLE.
REQ-036 Reset asserted with val=9 in RUN, between clock edges: val SHALL be 0 and busy=0 at once; after release, val SHALL hold 0 despite en.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types for the prescaled counter: the operating modes and the FSM states.
package counter_pkg;

    typedef enum logic [1:0] {
        PERIODIC = 2'd0,
        ONESHOT  = 2'd1,
        UPDOWN   = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The unused encoding 3 behaves as PERIODIC.
    function automatic mode_t decode_mode(input logic [1:0] m);
        case (m)
            2'd1:    return ONESHOT;
            2'd2:    return UPDOWN;
            default: return PERIODIC;
        endcase
    endfunction

endpackage

// File: rtl/prescaled_counter_prescaler.sv
// Divides the en strobe: tick fires on the en that finds the count equal to div.
module prescaler #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clear,
    input  logic [WIDTH-1:0] div,
    output logic             tick
);

    logic [WIDTH-1:0] cnt_q;

    assign tick = en && (cnt_q == div);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= tick ? '0 : cnt_q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/prescaled_counter.sv
// Run-controlled counter with periodic, one-shot and up/down modes, advanced by
// prescaled ticks of en; mode, max and prescale are captured on start.
module prescaled_counter
    import counter_pkg::*;
#(
    parameter int unsigned COUNTER_WIDTH  = 16,
    parameter int unsigned PRESCALE_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic                      start,
    input  logic                      stop,
    input  logic [1:0]                mode,
    input  logic [COUNTER_WIDTH-1:0]  max,
    input  logic [COUNTER_WIDTH-1:0]  cmp,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic [COUNTER_WIDTH-1:0]  val,
    output logic                      top,
    output logic                      top_pulse,
    output logic                      cmp_pulse,
    output logic                      dir,
    output logic                      busy
);

    state_t                    state_q;
    mode_t                     mode_q;
    logic [COUNTER_WIDTH-1:0]  val_q, val_d, max_q;
    logic [PRESCALE_WIDTH-1:0] pre_q;
    logic                      dir_q, dir_d, done_d;
    logic                      top_pulse_q, cmp_pulse_q;
    logic                      tick, run_start;

    assign run_start = start && !stop;

    prescaler #(.WIDTH(PRESCALE_WIDTH)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (en && (state_q == RUN)),
        .clear (run_start),
        .div   (pre_q),
        .tick  (tick)
    );

    always_comb begin
        val_d  = val_q + COUNTER_WIDTH'(1);
        dir_d  = dir_q;
        done_d = 1'b0;
        case (mode_q)
            ONESHOT: begin
                if (val_q >= max_q) begin
                    val_d  = max_q;
                    done_d = 1'b1;
                end
            end
            UPDOWN: begin
                if (max_q == '0) begin
                    val_d = '0;
                    dir_d = 1'b0;
                end else if (!dir_q) begin
                    dir_d = (val_d >= max_q);
                end else begin
                    val_d = val_q - COUNTER_WIDTH'(1);
                    dir_d = (val_d != '0);
                end
            end
            default: begin
                if (val_q >= max_q) val_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            mode_q      <= PERIODIC;
            val_q       <= '0;
            max_q       <= '0;
            pre_q       <= '0;
            dir_q       <= 1'b0;
            top_pulse_q <= 1'b0;
            cmp_pulse_q <= 1'b0;
        end else begin
            top_pulse_q <= 1'b0;
            cmp_pulse_q <= 1'b0;
            if (stop) begin
                state_q <= IDLE;
            end else if (start) begin
                state_q <= RUN;
                val_q   <= '0;
                dir_q   <= 1'b0;
                mode_q  <= decode_mode(mode);
                max_q   <= max;
                pre_q   <= prescale;
            end else if (state_q == RUN && tick) begin
                val_q <= val_d;
                dir_q <= dir_d;
                // The tick that finishes a one-shot enters DONE, where pulses stay low.
                if (done_d) begin
                    state_q <= DONE;
                end else begin
                    top_pulse_q <= (val_d == max_q);
                    cmp_pulse_q <= (val_d == cmp);
                end
            end
        end
    end

    assign val       = val_q;
    assign top       = (val_q == max_q);
    assign top_pulse = top_pulse_q;
    assign cmp_pulse = cmp_pulse_q;
    assign dir       = dir_q;
    assign busy      = (state_q == RUN);

endmodule
